// File: rtl/led_pulse_stretch.sv
// Event-to-LED stretcher: each rising edge of i_evt becomes a fixed-length blink
// followed by a guaranteed dark gap; events arriving during a blink are queued.
module led_pulse_stretch #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int PEND_MAX   = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_evt,
  output logic                            o_led,
  output logic                            o_busy,
  output logic [$clog2(PEND_MAX+1)-1:0]   o_pend,
  output logic                            o_drop
);

  localparam int PW      = $clog2(PEND_MAX + 1);
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD  = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          prev_evt_q;
  logic          led_q, busy_q, drop_q;
  logic          evt_edge, inc, dec, drop_d;

  assign evt_edge = i_evt & ~prev_evt_q;

  // The counter holds "cycles left minus one" in the current state, so zero marks the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt_edge) begin
          state_d = ON;
          cnt_d   = ON_LOAD;
        end
      end
      ON: begin
        inc = evt_edge;
        if (cnt_q == '0) begin
          state_d = OFF;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      OFF: begin
        if (cnt_q == '0) begin
          if (pend_q != '0) begin
            dec     = 1'b1;
            inc     = evt_edge;
            state_d = ON;
            cnt_d   = ON_LOAD;
          end else if (evt_edge) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          inc   = evt_edge;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A simultaneous queue-and-replay cancels out, which also keeps a full queue from dropping.
  always_comb begin
    pend_d = pend_q;
    drop_d = 1'b0;
    if (inc && !dec) begin
      if (pend_q == PEND_FULL) begin
        drop_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      prev_evt_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      prev_evt_q <= i_evt;
      led_q      <= (state_d == ON);
      busy_q     <= (state_d != IDLE);
      drop_q     <= drop_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_pend = pend_q;
  assign o_drop = drop_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Self-checking bench for led_pulse_stretch: directed scenarios plus random traffic,
// compared every cycle against a blink-schedule model built from start times.
module tb_led_pulse_stretch;

  localparam int ON  = 8;
  localparam int OFF = 4;
  localparam int PM  = 3;
  localparam int PW  = $clog2(PM + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_evt = 1'b0;
  logic          o_led, o_busy, o_drop;
  logic [PW-1:0] o_pend;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: a blink occupies periods [m_start, m_start+ON+OFF); queued events wait in m_pend.
  bit m_active = 0;
  int m_start = 0;
  int m_pend = 0;
  bit m_drop = 0;
  bit m_prev = 0;

  led_pulse_stretch #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .i_evt(i_evt),
    .o_led(o_led), .o_busy(o_busy), .o_pend(o_pend), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_active = 0;
    m_start  = 0;
    m_pend   = 0;
    m_drop   = 0;
    m_prev   = 0;
  endtask

  task automatic modelEdge(input logic evt);
    bit e;
    e = evt && !m_prev;
    m_prev = evt;
    m_drop = 0;
    if (!m_active) begin
      if (e) begin
        m_active = 1;
        m_start  = cyc;
      end
    end else if (cyc - m_start == ON + OFF) begin
      if (m_pend > 0) begin
        m_start = cyc;
        if (!e) m_pend--;
      end else if (e) begin
        m_start = cyc;
      end else begin
        m_active = 0;
      end
    end else if (e) begin
      if (m_pend == PM) m_drop = 1;
      else m_pend++;
    end
  endtask

  task automatic expectBit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0b expected %0b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic          exp_led;
    logic [PW-1:0] exp_pend;
    int            pend_v;
    pend_v   = m_pend;
    exp_led  = m_active && (cyc - m_start < ON);
    exp_pend = pend_v[PW-1:0];
    expectBit({tag, ".led"}, o_led, exp_led);
    expectBit({tag, ".busy"}, o_busy, m_active);
    expectBit({tag, ".drop"}, o_drop, m_drop);
    checks++;
    assert (o_pend === exp_pend) else begin
      errors++;
      $error("[TB] FAIL %s.pend got %0d expected %0d at cycle %0d", tag, o_pend, exp_pend, cyc);
    end
  endtask

  // Drive one period's input, then check the outputs produced by the following edge.
  task automatic applyStimulus(input logic evt, input string tag);
    i_evt = evt;
    @(posedge clk);
    #1;
    cyc++;
    modelEdge(evt);
    checkOutput(tag);
  endtask

  // Asserted between edges so the clear is observed asynchronously before any clock.
  task automatic doReset(input logic evt_at_release);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async");
    for (int i = 0; i < 3; i++) begin
      i_evt = i[0];
      @(posedge clk);
      #1;
      checkOutput("reset_hold");
    end
    i_evt = evt_at_release;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int density;
    int len;
    @(posedge clk);
    #1;

    $display("[TB] reset with toggling input");
    doReset(1'b0);

    $display("[TB] single pulse");
    for (int p = 0; p < 30; p++) begin
      applyStimulus(p == 10, "single");
      if (cyc == 11) expectBit("single.rise", o_led, 1'b1);
      if (cyc == 19) expectBit("single.fall", o_led, 1'b0);
      if (cyc == 23) expectBit("single.idle", o_busy, 1'b0);
    end

    $display("[TB] held input");
    doReset(1'b0);
    for (int p = 0; p < 130; p++) applyStimulus(p >= 10 && p <= 110, "held");

    $display("[TB] saturation");
    doReset(1'b0);
    for (int p = 0; p < 62; p++) begin
      applyStimulus(p == 10 || p == 12 || p == 14 || p == 16 || p == 18, "sat");
      if (cyc == 17) expectBit("sat.pend_full", o_pend == PW'(PM), 1'b1);
      if (cyc == 19) expectBit("sat.drop", o_drop, 1'b1);
      if (cyc == 54) expectBit("sat.last_blink", o_led, 1'b1);
      if (cyc == 59) expectBit("sat.idle", o_busy, 1'b0);
    end

    $display("[TB] back-to-back chaining");
    doReset(1'b0);
    for (int p = 0; p < 40; p++) begin
      applyStimulus(p == 10 || p == 22, "chain");
      if (cyc == 23) expectBit("chain.rerise", o_led, 1'b1);
    end

    $display("[TB] mid-blink reset");
    doReset(1'b0);
    for (int p = 0; p < 14; p++) applyStimulus(p == 10 || p == 12, "midrst");
    expectBit("midrst.pend_before", o_pend == PW'(1), 1'b1);
    doReset(1'b0);
    for (int p = 0; p < 25; p++) applyStimulus(1'b0, "midrst.after");

    $display("[TB] input already high at reset release");
    doReset(1'b1);
    for (int p = 0; p < 20; p++) applyStimulus(p < 5, "relhigh");

    $display("[TB] random traffic");
    doReset(1'b0);
    for (int blk = 0; blk < 16; blk++) begin
      density = $urandom_range(5, 90);
      len = $urandom_range(100, 250);
      for (int p = 0; p < len; p++) begin
        applyStimulus($urandom_range(0, 99) < density, "rand");
        if ($urandom_range(0, 299) == 0) doReset(1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretch.md
LED_PULSE_STRETCH -- requirements
Module: led_pulse_stretch

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 8, the number of cycles o_led is held high per blink (legal range >= 1).
REQ-002 SHALL have parameter OFF_CYCLES, default 4, the number of guaranteed-low gap cycles after each blink (legal range >= 1).
REQ-003 SHALL have parameter PEND_MAX, default 3, the saturation limit of the pending-event counter (legal range >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_evt, input, 1 bit: event request, synchronous to clk; only rising edges count.
REQ-007 SHALL have port o_led, output, 1 bit: stretched blink output, registered.
REQ-008 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 SHALL have port o_pend, output, $clog2(PEND_MAX+1) bits: current pending-event count.
REQ-010 SHALL have port o_drop, output, 1 bit: one-cycle pulse when an event is lost to saturation.

Function
REQ-011 SHALL detect a rising edge as i_evt==1 at the current clk edge with registered prev_evt==0; prev_evt resets to 0.
REQ-012 SHALL implement a three-state FSM: IDLE, ON and OFF.
REQ-013 SHALL, in IDLE on a detected edge, enter ON at the next clock without incrementing the pending counter, so o_led rises 1 cycle after the sampling edge.
REQ-014 SHALL hold o_led=1 for exactly ON_CYCLES consecutive cycles in ON, then enter OFF.
REQ-015 SHALL hold o_led=0 for exactly OFF_CYCLES consecutive cycles in OFF.
REQ-016 SHALL, at the end of OFF with pending>0, decrement pending and enter ON with no IDLE cycle in between.
REQ-017 SHALL, at the end of OFF with pending==0 and an edge detected that same cycle, consume the edge and enter ON directly.
REQ-018 SHALL, at the end of OFF otherwise, enter IDLE.
REQ-019 SHALL increment pending on an edge detected while in ON or OFF, except where REQ-017 applies.
REQ-020 SHALL, on an edge at pending==PEND_MAX, leave pending unchanged and assert o_drop for exactly that one following cycle.
REQ-021 SHALL leave pending unchanged when increment and decrement coincide; net 0, and no drop.
REQ-022 SHALL use a single down-counter of width $clog2(max(ON_CYCLES,OFF_CYCLES)+1), reloaded on every state entry and never wrapping.
REQ-023 SHALL keep i_evt held high as exactly one event, regardless of duration.

Reset
REQ-024 SHALL, while rst_n==0, asynchronously force: state IDLE, o_led 0, o_busy 0, o_pend 0, o_drop 0, counter 0, prev_evt 0.
REQ-025 SHALL abort any blink in progress when reset is asserted mid-operation; pending events are discarded and not replayed.
REQ-026 SHALL, on the first clock after rst_n deassertion, treat i_evt already high as a rising edge, since prev_evt==0.

Verification (ON=8, OFF=4, PEND_MAX=3; cycle N = Nth rising clk edge)
REQ-027 SHALL cover reset: rst_n low for 3 cycles with i_evt toggling -> o_led, o_busy, o_pend and o_drop all 0 throughout.
REQ-028 SHALL cover a single pulse: i_evt high at cycle 10 only -> o_led high cycles 11-18, low from 19; o_busy high 11-22; IDLE at 23.
REQ-029 SHALL cover a held input: i_evt high from cycle 10 to 110 -> exactly one blink (o_led high 11-18), o_pend stays 0.
REQ-030 SHALL cover saturation: 1-cycle pulses at cycles 10, 12, 14, 16, 18 -> o_pend reaches 3 at 17, o_drop high once at cycle 19. Expected blinks, exactly 4, ON at 11-18, 23-30, 35-42 and 47-54; IDLE at 59.
REQ-031 SHALL cover back-to-back chaining: pulse at 10, then a second pulse sampled at cycle 22 (last OFF cycle) -> o_led high again 23-30, o_busy never drops, o_pend stays 0.
REQ-032 SHALL cover mid-blink reset: pulse at 10 and a pending pulse at 12, then rst_n low at cycle 14 -> o_led 0 and o_pend 0 immediately (asynchronous); no blink after release with i_evt low.
